// File: rtl/ctr_multi_pkg.sv
// Shared types and helpers for the ctr_multi reciprocal counter.
// The optional watchdog is enabled with the CTR_TIMEOUT_EN macro.
package ctr_multi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN,
        ST_ARM,
        ST_DONE
    } ctr_st_e;

    localparam int TMO_DEF = 2 ** 20;

    // Select word layout: [selw] = invert, [selw-1:0] = channel index.
    function automatic logic sel_inv(input logic [31:0] sel, input int selw);
        return sel[selw];
    endfunction

    function automatic int unsigned sel_chn(input logic [31:0] sel, input int selw);
        return sel & ((32'd1 << selw) - 32'd1);
    endfunction

endpackage

// File: rtl/ctr_multi_if.sv
// Controller-side bus of ctr_multi: select words, gate time, handshake and results.
interface ctr_multi_if #(
    parameter int SIZE = 32,
    parameter int SELW = 1
);
    logic [SELW:0]     bis;
    logic [SELW:0]     eis;
    logic [SELW:0]     ecs;
    logic [SIZE-1:0]   gtm;
    logic              req;
    logic              abt;
    logic              bac;
    logic              eac;
    logic [SIZE-1:0]   cte;
    logic [SIZE-1:0]   ctc;
    logic              ovf;
    logic              tmo;

    modport master (
        output bis, eis, ecs, gtm, req, abt,
        input  bac, eac, cte, ctc, ovf, tmo
    );

    modport slave (
        input  bis, eis, ecs, gtm, req, abt,
        output bac, eac, cte, ctc, ovf, tmo
    );
endinterface

// File: rtl/ctr_multi_edge.sv
// Per-channel 2-FF synchroniser followed by an edge register; flags rising
// and falling edges of the synchronised level.
module ctr_multi_edge #(
    parameter int CHN = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CHN-1:0] inp_i,
    output logic [CHN-1:0] rse_o,
    output logic [CHN-1:0] fle_o
);

    logic [CHN-1:0] s1_q;
    logic [CHN-1:0] s2_q;
    logic [CHN-1:0] prv_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            prv_q <= '0;
        end else begin
            s1_q  <= inp_i;
            s2_q  <= s1_q;
            prv_q <= s2_q;
        end
    end

    assign rse_o = s2_q & ~prv_q;
    assign fle_o = ~s2_q & prv_q;

endmodule

// File: rtl/ctr_multi.sv
// Reciprocal counter: selectable begin/end/count sources, saturating event and
// clock counters, minimum gate time. CTR_TIMEOUT_EN adds a WAIT/RUN/ARM watchdog.
module ctr_multi
    import ctr_multi_pkg::*;
#(
    parameter int CHN  = 2,
    parameter int SIZE = 32,
    parameter int SELW = (CHN > 1) ? $clog2(CHN) : 1,
    parameter int TMO  = TMO_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [CHN-1:0] inp,
    ctr_multi_if.slave     bus
);

    logic [CHN-1:0]  rse;
    logic [CHN-1:0]  fle;

    ctr_multi_edge #(.CHN(CHN)) u_edge (
        .clk   (clk),
        .rst   (rst),
        .inp_i (inp),
        .rse_o (rse),
        .fle_o (fle)
    );

    ctr_st_e         st_q;
    logic [SELW:0]   bis_q;
    logic [SELW:0]   eis_q;
    logic [SELW:0]   ecs_q;
    logic [SIZE-1:0] cte_q;
    logic [SIZE-1:0] ctc_q;
    logic            bac_q;
    logic            eac_q;
    logic            ovf_q;
    logic            tmo_q;

    logic            beg_e;
    logic            end_e;
    logic            cnt_e;
    logic [SIZE-1:0] cte_d;
    logic [SIZE-1:0] ctc_d;
    logic            cte_sat;
    logic            ctc_sat;
    logic            gate_ok;
    logic            wdg_hit;
    logic [SIZE:0]   ctc_inc;

    // Out-of-range channel indices resolve to a constant, so they never edge.
    function automatic logic pick(input logic [SELW:0] sel,
                                  input logic [CHN-1:0] r,
                                  input logic [CHN-1:0] f);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < CHN; i++) begin
            if (sel_chn(32'(sel), SELW) == unsigned'(i))
                hit = sel_inv(32'(sel), SELW) ? f[i] : r[i];
        end
        return hit;
    endfunction

    // Returns {saturated, value}; the value sticks at all-ones.
    function automatic logic [SIZE:0] sat_inc(input logic [SIZE-1:0] v, input logic inc);
        logic [SIZE:0] s;
        s = {1'b0, v} + {{SIZE{1'b0}}, inc};
        if (s[SIZE])
            return {1'b1, {SIZE{1'b1}}};
        return s;
    endfunction

    always_comb begin
        beg_e              = pick(bis_q, rse, fle);
        end_e              = pick(eis_q, rse, fle);
        cnt_e              = pick(ecs_q, rse, fle);
        {ctc_sat, ctc_d}   = sat_inc(ctc_q, 1'b1);
        {cte_sat, cte_d}   = sat_inc(cte_q, cnt_e);
        ctc_inc            = {1'b0, ctc_q} + {{SIZE{1'b0}}, 1'b1};
        gate_ok            = ctc_inc >= {1'b0, bus.gtm};
    end

`ifdef CTR_TIMEOUT_EN
    localparam logic [SIZE-1:0] WDG_LIM = SIZE'(TMO - 1);
    logic [SIZE-1:0] wdg_q;

    // WAIT is only entered from IDLE, so clearing outside the gate states
    // guarantees a fresh count on every entry into WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            wdg_q <= '0;
        else if (st_q == ST_IDLE || st_q == ST_DONE)
            wdg_q <= '0;
        else
            wdg_q <= wdg_q + 1'b1;
    end

    assign wdg_hit = (st_q == ST_WAIT || st_q == ST_RUN || st_q == ST_ARM) &&
                     (wdg_q == WDG_LIM);
`else
    assign wdg_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q  <= ST_IDLE;
            bis_q <= '0;
            eis_q <= '0;
            ecs_q <= '0;
            cte_q <= '0;
            ctc_q <= '0;
            bac_q <= 1'b0;
            eac_q <= 1'b0;
            ovf_q <= 1'b0;
            tmo_q <= 1'b0;
        end else if (bus.abt) begin
            st_q  <= ST_IDLE;
            bac_q <= 1'b0;
            eac_q <= 1'b0;
        end else if (wdg_hit) begin
            st_q  <= ST_IDLE;
            bac_q <= 1'b0;
            tmo_q <= 1'b1;
        end else begin
            case (st_q)
                ST_IDLE: if (bus.req) begin
                    st_q  <= ST_WAIT;
                    bis_q <= bus.bis;
                    eis_q <= bus.eis;
                    ecs_q <= bus.ecs;
                    cte_q <= '0;
                    ctc_q <= '0;
                    ovf_q <= 1'b0;
                    tmo_q <= 1'b0;
                end
                ST_WAIT: begin
                    if (!bus.req) begin
                        st_q <= ST_IDLE;
                    end else if (beg_e) begin
                        st_q  <= ST_RUN;
                        bac_q <= 1'b1;
                        cte_q <= '0;
                        ctc_q <= '0;
                    end
                end
                ST_RUN, ST_ARM: begin
                    ctc_q <= ctc_d;
                    cte_q <= cte_d;
                    if (ctc_sat || cte_sat)
                        ovf_q <= 1'b1;
                    if (st_q == ST_RUN && gate_ok)
                        st_q <= ST_ARM;
                    if (st_q == ST_ARM && end_e) begin
                        st_q  <= ST_DONE;
                        bac_q <= 1'b0;
                        eac_q <= 1'b1;
                    end
                end
                ST_DONE: if (!bus.req) begin
                    st_q  <= ST_IDLE;
                    eac_q <= 1'b0;
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.bac = bac_q;
    assign bus.eac = eac_q;
    assign bus.cte = cte_q;
    assign bus.ctc = ctc_q;
    assign bus.ovf = ovf_q;
`ifdef CTR_TIMEOUT_EN
    assign bus.tmo = tmo_q;
`else
    assign bus.tmo = 1'b0;
`endif

endmodule

// File: tb/tb_ctr_multi.sv
// Directed bench for ctr_multi: three instances (main, 4-bit counters, watchdog).
module tb_ctr_multi;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in0 = 1'b0;
    logic in1 = 1'b0;
    int   n_chk = 0;
    int   n_ok  = 0;

    always #5 clk = ~clk;

    ctr_multi_if #(.SIZE(32), .SELW(1)) ai ();
    ctr_multi_if #(.SIZE(4),  .SELW(1)) bi ();
    ctr_multi_if #(.SIZE(32), .SELW(1)) ci ();

    ctr_multi #(.CHN(2), .SIZE(32)) u_a (
        .clk (clk), .rst (rst), .inp ({in1, in0}), .bus (ai.slave));
    ctr_multi #(.CHN(2), .SIZE(4)) u_b (
        .clk (clk), .rst (rst), .inp ({in1, in0}), .bus (bi.slave));
    ctr_multi #(.CHN(2), .SIZE(32), .TMO(64)) u_c (
        .clk (clk), .rst (rst), .inp ({in1, in0}), .bus (ci.slave));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        else
            n_ok++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        ai.bis = '0; ai.eis = '0; ai.ecs = '0; ai.gtm = '0; ai.req = 1'b0; ai.abt = 1'b0;
        bi.bis = '0; bi.eis = '0; bi.ecs = '0; bi.gtm = '0; bi.req = 1'b0; bi.abt = 1'b0;
        ci.bis = '0; ci.eis = '0; ci.ecs = '0; ci.gtm = '0; ci.req = 1'b0; ci.abt = 1'b0;

        // Reset state
        tick(3);
        check("rst_bac", ai.bac, 0);
        check("rst_eac", ai.eac, 0);
        check("rst_cte", ai.cte, 0);
        check("rst_ctc", ai.ctc, 0);
        check("rst_ovf", ai.ovf, 0);
        check("rst_tmo", ai.tmo, 0);

        // Async reset in the middle of a gate
        rst = 1'b1;
        tick(2);
        ai.gtm = 32'd1000; ai.req = 1'b1;
        tick(2);
        in0 = 1'b1;
        tick(10);
        check("run_bac", ai.bac, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_bac", ai.bac, 0);
        check("arst_ctc", ai.ctc, 0);
        check("arst_cte", ai.cte, 0);
        @(negedge clk);
        rst = 1'b1; ai.req = 1'b0; in0 = 1'b0;
        tick(5);

        // Basic gate: 10-cycle square, gtm=95 -> ten periods
        ai.gtm = 32'd95; ai.req = 1'b1;
        tick(2);
        for (int i = 0; i < 30; i++) begin
            tick(5);
            in0 = ~in0;
        end
        check("basic_eac", ai.eac, 1);
        check("basic_bac", ai.bac, 0);
        check("basic_ctc", ai.ctc, 100);
        check("basic_cte", ai.cte, 10);
        check("basic_ovf", ai.ovf, 0);
        ai.req = 1'b0;
        tick(2);
        check("basic_eac_drop", ai.eac, 0);
        check("basic_cte_held", ai.cte, 10);

        // Inverted selects: begin on ch0 fall, end on ch1 fall, count ch0 rises
        ai.bis = 2'b10; ai.eis = 2'b11; ai.ecs = 2'b00; ai.gtm = 32'd1;
        in0 = 1'b1; in1 = 1'b1;
        tick(6);
        ai.req = 1'b1;
        tick(2);
        in0 = 1'b0;
        tick(5); in0 = 1'b1;
        tick(5); in0 = 1'b0;
        tick(5); in0 = 1'b1;
        tick(5); in0 = 1'b0;
        tick(3); in1 = 1'b0;
        tick(6);
        check("inv_eac", ai.eac, 1);
        check("inv_ctc", ai.ctc, 23);
        check("inv_cte", ai.cte, 2);
        ai.req = 1'b0;
        tick(2);

        // gtm=0 with bis==eis: the begin edge does not also close the gate
        ai.bis = 2'b00; ai.eis = 2'b00; ai.ecs = 2'b00; ai.gtm = 32'd0;
        in0 = 1'b0; in1 = 1'b0;
        tick(5);
        ai.req = 1'b1;
        tick(2);
        in0 = 1'b1;
        tick(3); in0 = 1'b0;
        tick(4); in0 = 1'b1;
        tick(6);
        check("g0_eac", ai.eac, 1);
        check("g0_ctc", ai.ctc, 7);
        check("g0_cte", ai.cte, 1);
        ai.req = 1'b0;
        tick(2);

        // Abort in ARM: IDLE next cycle, counters hold, no result
        in0 = 1'b0;
        tick(5);
        ai.req = 1'b1;
        tick(2);
        in0 = 1'b1;
        tick(6);
        check("abt_pre_bac", ai.bac, 1);
        ai.abt = 1'b1;
        tick(1);
        check("abt_bac", ai.bac, 0);
        check("abt_eac", ai.eac, 0);
        check("abt_ctc", ai.ctc, 3);
        ai.abt = 1'b0; ai.req = 1'b0; in0 = 1'b0;
        tick(3);
        in0 = 1'b1;
        tick(6);
        check("abt_eac_late", ai.eac, 0);
        check("abt_ctc_held", ai.ctc, 3);

`ifndef CTR_TIMEOUT_EN
        // SIZE=4: ~50 count edges saturate at 15 without wrapping
        bi.bis = 2'b00; bi.eis = 2'b00; bi.ecs = 2'b01; bi.gtm = 4'd15;
        in0 = 1'b0; in1 = 1'b0;
        tick(5);
        bi.req = 1'b1;
        tick(2);
        for (int i = 0; i < 120; i++) begin
            if (i == 0)   in0 = 1'b1;
            if (i == 50)  in0 = 1'b0;
            if (i == 100) in0 = 1'b1;
            in1 = ~in1;
            tick(1);
        end
        tick(4);
        check("sat_eac", bi.eac, 1);
        check("sat_cte", bi.cte, 15);
        check("sat_ctc", bi.ctc, 15);
        check("sat_ovf", bi.ovf, 1);
        bi.req = 1'b0;
        tick(2);
        bi.req = 1'b1;
        tick(2);
        check("sat_ovf_clr", bi.ovf, 0);
        check("sat_cte_clr", bi.cte, 0);
        bi.req = 1'b0;
        tick(2);
`endif

        // Watchdog: no begin edge while waiting
        in0 = 1'b0; in1 = 1'b0;
        tick(5);
        ci.req = 1'b1;
        tick(64);
        check("wdg_tmo_early", ci.tmo, 0);
        tick(1);
`ifdef CTR_TIMEOUT_EN
        check("wdg_tmo", ci.tmo, 1);
`else
        check("wdg_tmo", ci.tmo, 0);
`endif
        check("wdg_bac", ci.bac, 0);
        ci.req = 1'b0;
        tick(2);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
